// File: rtl/mem_cache_if.sv
// mem_cache_if: pipeline-side and SRAM-side signals of the data cache controller.
interface mem_cache_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        freeze;
    logic        sram_wr_en;
    logic        sram_rd_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;
    modport slave (
        input  wr_en, rd_en, address, write_data, sram_rdata, sram_ready,
        output read_data, freeze, sram_wr_en, sram_rd_en, sram_address, sram_wdata
    );
    modport master (
        output wr_en, rd_en, address, write_data, sram_rdata, sram_ready,
        input  read_data, freeze, sram_wr_en, sram_rd_en, sram_address, sram_wdata
    );
endinterface

// File: rtl/mem_cache_controller.sv
// mem_cache_controller: 2-way set-associative write-through, no-write-allocate data cache.
// Defining CACHE_STATS_EN adds hit_count/miss_count output ports.
module mem_cache_controller #(
    parameter int SETS_LOG2 = 6,
    parameter int TAG_W     = 11
) (
    input  logic        clk,
    input  logic        rst,
    mem_cache_if.slave  bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int SETS = 1 << SETS_LOG2;
    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
    state_t state, state_n;
    logic [SETS_LOG2-1:0] idx, l_idx;
    logic [TAG_W-1:0]     tag, l_tag;
    logic [31:0]          addr_q, wdata_q, rd_q, hit_data;
    logic [SETS-1:0]      valid0, valid1, lru;
    logic [TAG_W-1:0]     tag0 [SETS];
    logic [TAG_W-1:0]     tag1 [SETS];
    logic [31:0]          data0 [SETS];
    logic [31:0]          data1 [SETS];
    logic                 idle, rd, hit0, hit1, hit, hit_way, victim, fill;
    assign idx      = bus.address[SETS_LOG2+1:2];
    assign tag      = bus.address[SETS_LOG2+TAG_W+1:SETS_LOG2+2];
    assign l_idx    = addr_q[SETS_LOG2+1:2];
    assign l_tag    = addr_q[SETS_LOG2+TAG_W+1:SETS_LOG2+2];
    assign idle     = state == IDLE;
    assign rd       = bus.rd_en & ~bus.wr_en;
    assign hit0     = valid0[idx] & (tag0[idx] == tag);
    assign hit1     = valid1[idx] & (tag1[idx] == tag);
    assign hit      = hit0 | hit1;
    assign hit_way  = hit1;
    assign hit_data = hit1 ? data1[idx] : data0[idx];
    assign victim   = ~valid0[l_idx] ? 1'b0 : ~valid1[l_idx] ? 1'b1 : lru[l_idx];
    assign fill     = (state == RD_MISS) & bus.sram_ready;
    always_comb begin
        state_n          = idle ? (bus.wr_en ? WR_THRU : (rd & ~hit) ? RD_MISS : IDLE)
                                : (bus.sram_ready ? IDLE : state);
        bus.freeze       = idle ? (bus.wr_en | (rd & ~hit)) : ~bus.sram_ready;
        bus.read_data    = (idle & rd & hit) ? hit_data : fill ? bus.sram_rdata : rd_q;
        bus.sram_rd_en   = state == RD_MISS;
        bus.sram_wr_en   = state == WR_THRU;
        bus.sram_address = addr_q;
        bus.sram_wdata   = wdata_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid0  <= '0;
            valid1  <= '0;
            lru     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            state <= state_n;
            rd_q  <= bus.read_data;
            if (idle & (bus.wr_en | bus.rd_en))
                addr_q <= bus.address;
            if (idle & bus.wr_en)
                wdata_q <= bus.write_data;
            if (idle & (bus.wr_en | bus.rd_en) & hit)
                lru[idx] <= ~hit_way;
            if (fill) begin
                lru[l_idx] <= ~victim;
                if (victim) valid1[l_idx] <= 1'b1;
                else        valid0[l_idx] <= 1'b1;
            end
        end
    end
    // Tag/data arrays need no reset: valid bits gate every lookup.
    always_ff @(posedge clk) begin
        if (idle & bus.wr_en & hit) begin
            if (hit_way) data1[idx] <= bus.write_data;
            else         data0[idx] <= bus.write_data;
        end
        if (fill) begin
            if (victim) begin
                tag1[l_idx]  <= l_tag;
                data1[l_idx] <= bus.sram_rdata;
            end else begin
                tag0[l_idx]  <= l_tag;
                data0[l_idx] <= bus.sram_rdata;
            end
        end
    end
`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (idle & rd) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_cache_controller.sv
// tb_mem_cache_controller: random and directed accesses against a recency-list cache model.
module tb_mem_cache_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_cache_if bus ();
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif
    mem_cache_controller dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );
    typedef struct {
        logic [10:0] tag;
        logic [31:0] data;
    } line_t;
    line_t       sets [64][$];
    logic [31:0] mem [logic [18:0]];
    logic [31:0] last_rd;
    int          n_chk, n_fail, m_hits, m_misses;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int find(input logic [5:0] ix, input logic [10:0] tg);
        for (int i = 0; i < sets[ix].size(); i++)
            if (sets[ix][i].tag == tg) return i;
        return -1;
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a[18:0])) mem[a[18:0]] = $urandom;
        return mem[a[18:0]];
    endfunction
    task automatic touch(input logic [5:0] ix, input int pos, input logic [31:0] d);
        line_t l;
        l = sets[ix][pos];
        l.data = d;
        sets[ix].delete(pos);
        sets[ix].push_front(l);
    endtask
    task automatic clear_model();
        for (int i = 0; i < 64; i++) sets[i].delete();
        m_hits = 0;
        m_misses = 0;
        last_rd = '0;
    endtask
    task automatic idle_inputs();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.sram_ready = 1'b0;
    endtask
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_freeze", {31'd0, bus.freeze}, 32'd0);
        check("rst_rd_en", {31'd0, bus.sram_rd_en}, 32'd0);
        check("rst_wr_en", {31'd0, bus.sram_wr_en}, 32'd0);
        check("rst_read_data", bus.read_data, 32'd0);
        check("rst_sram_addr", bus.sram_address, 32'd0);
        clear_model();
    endtask
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, input int lat);
        logic [5:0]  ix;
        logic [10:0] tg;
        logic [31:0] exp;
        line_t       l;
        int          pos;
        ix  = a[7:2];
        tg  = a[18:8];
        pos = find(ix, tg);
        @(negedge clk);
        bus.sram_ready = 1'($urandom_range(0, 1));
        bus.sram_rdata = $urandom;
        #1;
        check("idle_freeze", {31'd0, bus.freeze}, 32'd0);
        check("idle_hold", bus.read_data, last_rd);
        @(negedge clk);
        bus.sram_ready = 1'b0;
        bus.wr_en      = wr;
        bus.rd_en      = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.address    = a;
        bus.write_data = d;
        #1;
        if (!wr && pos >= 0) begin
            exp = sets[ix][pos].data;
            check("hit_freeze", {31'd0, bus.freeze}, 32'd0);
            check("hit_data", bus.read_data, exp);
            check("hit_no_sram", {30'd0, bus.sram_rd_en, bus.sram_wr_en}, 32'd0);
            touch(ix, pos, exp);
            last_rd = exp;
            m_hits++;
            @(posedge clk);
            #1;
        end else begin
            check("req_freeze", {31'd0, bus.freeze}, 32'd1);
            check("req_no_sram", {30'd0, bus.sram_rd_en, bus.sram_wr_en}, 32'd0);
            if (!wr) m_misses++;
            @(posedge clk);
            for (int c = 0; c <= lat; c++) begin
                @(negedge clk);
                bus.sram_rdata = $urandom;
                if (c == lat) begin
                    bus.sram_ready = 1'b1;
                    if (!wr) bus.sram_rdata = mem_rd(a);
                end
                #1;
                check(wr ? "sram_wr_en" : "sram_rd_en", {31'd0, wr ? bus.sram_wr_en : bus.sram_rd_en}, 32'd1);
                check("sram_other_en", {31'd0, wr ? bus.sram_rd_en : bus.sram_wr_en}, 32'd0);
                check("sram_addr", bus.sram_address, a);
                if (wr) check("sram_wdata", bus.sram_wdata, d);
                check("busy_freeze", {31'd0, bus.freeze}, (c == lat) ? 32'd0 : 32'd1);
                if (!wr && c == lat) check("fill_data", bus.read_data, mem_rd(a));
            end
            if (wr) begin
                mem[a[18:0]] = d;
                if (pos >= 0) touch(ix, pos, d);
            end else begin
                l.tag  = tg;
                l.data = mem_rd(a);
                sets[ix].push_front(l);
                if (sets[ix].size() > 2) void'(sets[ix].pop_back());
                last_rd = l.data;
            end
            @(posedge clk);
            #1;
            bus.sram_ready = 1'b0;
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask
    task automatic reset_mid_miss(input logic [31:0] a);
        @(negedge clk);
        bus.rd_en   = 1'b1;
        bus.address = a;
        @(negedge clk);
        @(negedge clk);
        check("mid_rd_en", {31'd0, bus.sram_rd_en}, 32'd1);
        rst = 1'b1;
        bus.rd_en = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_rd_en", {31'd0, bus.sram_rd_en}, 32'd0);
        check("mid_rst_freeze", {31'd0, bus.freeze}, 32'd0);
        check("mid_rst_read_data", bus.read_data, 32'd0);
        rst = 1'b0;
        clear_model();
    endtask
    initial begin
        n_chk = 0;
        n_fail = 0;
        bus.address = '0;
        bus.write_data = '0;
        bus.sram_rdata = '0;
        idle_inputs();
        clear_model();
        reset_dut();
        mem[19'h400] = 32'hDEADBEEF;
        access(0, 32'h400, 0, 5);
        check("cold_data_held", last_rd, 32'hDEADBEEF);
        access(0, 32'h400, 0, 0);
        reset_dut();
        access(0, 32'h400, 0, 1);
        access(0, 32'h500, 0, 2);
        access(0, 32'h600, 0, 0);
        access(0, 32'h500, 0, 0);
        access(0, 32'h400, 0, 3);
`ifdef CACHE_STATS_EN
        check("lru_hit_count", hit_count, 32'd1);
        check("lru_miss_count", miss_count, 32'd4);
`endif
        access(1, 32'h500, 32'h12345678, 2);
        access(0, 32'h500, 0, 0);
        check("write_hit_data", last_rd, 32'h12345678);
        access(1, 32'h700, 32'hCAFEF00D, 1);
        access(0, 32'h700, 0, 2);
        check("write_miss_data", last_rd, 32'hCAFEF00D);
        reset_mid_miss(32'h800);
        access(0, 32'h500, 0, 1);
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = {13'($urandom), 11'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 2'b00};
            access($urandom_range(0, 3) == 0, a, $urandom, $urandom_range(0, 3));
        end
`ifdef CACHE_STATS_EN
        check("final_hit_count", hit_count, 32'(m_hits));
        check("final_miss_count", miss_count, 32'(m_misses));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_cache_controller.md
Name: mem_cache_controller

Overview:
- 2-way set-associative, write-through, no-write-allocate data cache.
- Sits between the pipeline MEM stage and the SRAM controller.
- Hits are served combinationally in the request cycle. Misses and all writes are forwarded to the SRAM controller, and the pipeline is frozen until the controller signals ready.
- One 32-bit word per line; valid bit per way; one LRU bit per set.

Parameters:
- SETS_LOG2, 6, log2 of set count; index = address[SETS_LOG2+1:2].
- TAG_W, 11, tag width; tag = address[SETS_LOG2+TAG_W+1:SETS_LOG2+2]. Address bits above the tag are ignored.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  MEM-stage store request, level, held while freeze=1.
- rd_en  in  1  MEM-stage load request, level, held while freeze=1.
- address  in  32  byte address of the request, word-aligned.
- write_data  in  32  store data.
- read_data  out  32  load data to the next stage.
- freeze  out  1  stall the pipeline this cycle.
- sram_wr_en  out  1  write request to the SRAM controller.
- sram_rd_en  out  1  read request to the SRAM controller.
- sram_address  out  32  request address, equal to the latched address.
- sram_wdata  out  32  request write data, equal to the latched write_data.
- sram_rdata  in  32  read data from the SRAM controller, valid when sram_ready=1.
- sram_ready  in  1  one-cycle completion pulse from the SRAM controller.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - state=IDLE; all valid bits=0; all LRU bits=0.
  - Latched address and data registers = 0.
  - Outputs: sram_wr_en=0, sram_rd_en=0, freeze=0, read_data=0.
  - Reset mid-transaction abandons the request; sram_* enables drop the next cycle.
- Lookup (IDLE, combinational): hit_w = valid[w][idx] & (tag_ram[w][idx]==tag).
- Request priority: wr_en and rd_en together is treated as a write.
- State IDLE:
  - rd_en & hit → read_data = data of the hit way; freeze=0. At the edge, LRU[idx] points to the other way.
  - rd_en & ~hit → freeze=1. Latch address; next state RD_MISS.
  - wr_en → freeze=1. Latch address and write_data.
    - If hit, update the hit way's data at this edge and set LRU to the other way.
    - No allocation on a write miss.
    - Next state WR_THRU.
  - No request → freeze=0; read_data holds its last value.
- State RD_MISS:
  - sram_rd_en=1 and sram_address=latched address. freeze=1, except in the sram_ready cycle.
  - On sram_ready:
    - read_data = sram_rdata and freeze=0 in the same cycle.
    - At the edge, fill the victim way (invalid way0 first, then invalid way1, else way LRU[idx]) with tag, data and valid=1.
    - LRU[idx] is set to point away from the filled way. Next state IDLE.
- State WR_THRU:
  - sram_wr_en=1; sram_address and sram_wdata = latched values. freeze=1, except in the sram_ready cycle.
  - On sram_ready → freeze=0; next state IDLE.
- Enable timing:
  - sram_rd_en and sram_wr_en are never asserted in IDLE, so the cycle after ready they are 0.
  - This prevents the SRAM controller from re-triggering on a stale request.
- Request hold: requests arriving while the FSM is not in IDLE are ignored; the MEM stage holds its request under freeze.
- Timing:
  - Miss latency = 1 + SRAM controller latency; the hit/miss decision is never registered.
  - sram_ready outside RD_MISS/WR_THRU is ignored.

Optional Feature:
- CACHE_STATS_EN defined: adds output ports hit_count[31:0] and miss_count[31:0], both reset to 0.
  - A read hit in IDLE increments hit_count by 1.
  - Entry into RD_MISS increments miss_count by 1.
  - Writes are not counted; counters wrap at 2^32.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Test Plan:
- Cold read miss:
  - rst, then read 0x400; SRAM model answers 0xDEADBEEF with ready 5 cycles later.
  - Required: sram_rd_en=1 with sram_address=0x400 from the next cycle; freeze=1 until the ready cycle; read_data=0xDEADBEEF with freeze=0 in the ready cycle.
  - Re-read 0x400 → hit: freeze=0 in the same cycle, no sram_rd_en.
- LRU eviction (0x400, 0x500 and 0x600 all map to index 0):
  - Read 0x400, then 0x500 (both miss), then 0x600 (miss, evicts 0x400).
  - Then 0x500 → hit; 0x400 → miss.
- Write hit:
  - After caching 0x500, write 0x12345678 to 0x500.
  - Required: sram_wr_en=1 with sram_wdata=0x12345678; freeze released on ready.
  - Read 0x500 → hit returning 0x12345678, no SRAM access.
- Write miss, no allocate: write 0xCAFEF00D to 0x700, then read 0x700 → miss, and sram_rd_en asserts.
- Reset mid-miss:
  - Assert rst for 1 cycle while in RD_MISS.
  - Required: sram_rd_en=0 and freeze=0 the next cycle; a read of the previously cached 0x500 misses.
- CACHE_STATS_EN: after the LRU eviction scenario → hit_count=1, miss_count=4.
